alu_muldiv_ctrl: RTL and testbench

- Next-generation ALU control for the MIPS core. Datapath width is a parameter.
- Performs the existing combinational ALUop/FuncCode → ALUCtrl decode for the single-cycle ALU.
- Adds an iterative multi-cycle multiply/divide unit with HI/LO registers for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Raises a combinational Stall to the pipeline hazard logic while the unit is busy.

---
 rtl/alu_muldiv_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: ALU control decode plus an iterative multiply/divide unit with HI/LO registers.
// Latency: ALUCtrl/Stall/UseMD/MDResult are combinational; MULT/MULTU/DIV/DIVU keep Busy high
//          for WIDTH+1 cycles after the issue edge, and the new Hi/Lo are visible when Busy falls.
// Backpressure: any mul/div instruction presented while Busy raises Stall. It is accepted on the
//               first cycle Busy=0.
// Ports: clk/reset (synchronous, active-high); ALUop, FuncCode, ExValid, SrcA, SrcB from EX;
//        ALUCtrl to the ALU; Stall to the hazard unit; Busy, UseMD, MDResult, Hi, Lo, DivByZero.
// Optional macro MULDIV_EARLY_EXIT_EN: a multiply leaves RUN as soon as the remaining multiplier
//        magnitude bits are zero. Results are unchanged; only the multiply latency shortens.
module alu_muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       ALUop,
   input  logic [5:0]       FuncCode,
   input  logic             ExValid,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [3:0]       ALUCtrl,
   output logic             Stall,
   output logic             Busy,
   output logic             UseMD,
   output logic [WIDTH-1:0] MDResult,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             DivByZero
);

   localparam logic [3:0] OP_RTYPE = 4'b1111;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               op_div;     // 1: divide in flight, 0: multiply
   logic               neg_res;    // negate product / quotient in FIXUP
   logic               neg_rem;    // negate remainder in FIXUP
   // Multiply: acc is the running product. Divide: acc = {partial remainder, dividend/quotient}.
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;      // multiplicand magnitude, shifted left each step
   logic [WIDTH-1:0]   opb;        // multiplier magnitude (shifted right) or divisor magnitude
   logic [WIDTH-1:0]   dividend;   // raw dividend, returned in Hi on divide by zero

   logic               rtype;
   logic               md_funct;
   logic               md_op;
   logic               issue;
   logic               signed_op;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               run_last;

   logic [2*WIDTH-1:0] mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               div_zero;

   // ------------------------------------------------------------------
   // Single-cycle ALU control decode
   // ------------------------------------------------------------------
   assign rtype = (ALUop == OP_RTYPE);

   always_comb begin
      ALUCtrl = ALUop;
      if (rtype) begin
         case (FuncCode)
            6'b000000: ALUCtrl = 4'b0011;   // SLL
            6'b000010: ALUCtrl = 4'b0100;   // SRL
            6'b000011: ALUCtrl = 4'b1101;   // SRA
            6'b100000: ALUCtrl = 4'b0010;   // ADD
            6'b100001: ALUCtrl = 4'b1000;   // ADDU
            6'b100010: ALUCtrl = 4'b0110;   // SUB
            6'b100011: ALUCtrl = 4'b1001;   // SUBU
            6'b100100: ALUCtrl = 4'b0000;   // AND
            6'b100101: ALUCtrl = 4'b0001;   // OR
            6'b100110: ALUCtrl = 4'b1010;   // XOR
            6'b100111: ALUCtrl = 4'b1100;   // NOR
            6'b101010: ALUCtrl = 4'b0111;   // SLT
            6'b101011: ALUCtrl = 4'b1011;   // SLTU
            default:   ALUCtrl = 4'b0000;   // includes all mul/div functs
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Mul/div issue and hazard signalling
   // ------------------------------------------------------------------
   assign md_funct = FuncCode inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                      F_MULT, F_MULTU, F_DIV, F_DIVU};
   assign md_op    = ExValid & rtype & md_funct;
   assign Busy     = (state != IDLE);
   assign Stall    = md_op & Busy;
   assign issue    = md_op & ~Busy;

   assign UseMD    = issue & ((FuncCode == F_MFHI) | (FuncCode == F_MFLO));
   assign MDResult = (UseMD && (FuncCode == F_MFHI)) ? Hi : Lo;

   // Signed variants work on magnitudes; the signs are reapplied in FIXUP.
   assign signed_op = (FuncCode == F_MULT) | (FuncCode == F_DIV);
   assign a_neg     = signed_op & SrcA[WIDTH-1];
   assign b_neg     = signed_op & SrcB[WIDTH-1];
   assign a_mag     = a_neg ? -SrcA : SrcA;
   assign b_mag     = b_neg ? -SrcB : SrcB;

   // ------------------------------------------------------------------
   // Iteration datapath
   // ------------------------------------------------------------------
   assign mul_sum = acc + (opb[0] ? mcand : '0);

   // Restoring division step: shift the next dividend bit into the partial
   // remainder, subtract the divisor when it fits, shift the quotient bit in.
   // While rem < divisor holds, the difference always fits in WIDTH bits.
   assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, opb});
   assign div_sub   = div_shift[WIDTH-1:0] - opb;
   assign div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

   assign prod_fix = neg_res ? -acc : acc;
   assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   assign div_zero = (opb == '0);

`ifdef MULDIV_EARLY_EXIT_EN
   // Once the multiplier bits still to be consumed are zero, acc already
   // holds the full product, so the remaining add steps can be skipped.
   assign run_last = (cnt == CNT_W'(1)) || (!op_div && (opb[WIDTH-1:1] == '0));
`else
   assign run_last = (cnt == CNT_W'(1));
`endif

   // ------------------------------------------------------------------
   // Control FSM with HI/LO registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         op_div    <= 1'b0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         opb       <= '0;
         dividend  <= '0;
         Hi        <= '0;
         Lo        <= '0;
         DivByZero <= 1'b0;
      end else begin
         DivByZero <= 1'b0;
         case (state)
            IDLE: begin
               if (issue) begin
                  case (FuncCode)
                     F_MTHI: Hi <= SrcA;
                     F_MTLO: Lo <= SrcA;
                     F_MULT, F_MULTU: begin
                        state   <= RUN;
                        cnt     <= CNT_W'(WIDTH);
                        op_div  <= 1'b0;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= 1'b0;
                        acc     <= '0;
                        mcand   <= {{WIDTH{1'b0}}, a_mag};
                        opb     <= b_mag;
                     end
                     F_DIV, F_DIVU: begin
                        state    <= RUN;
                        cnt      <= CNT_W'(WIDTH);
                        op_div   <= 1'b1;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        acc      <= {{WIDTH{1'b0}}, a_mag};
                        opb      <= b_mag;
                        dividend <= SrcA;
                     end
                     default: ;   // MFHI/MFLO only read Hi/Lo
                  endcase
               end
            end

            RUN: begin
               cnt <= cnt - CNT_W'(1);
               if (op_div) begin
                  acc <= div_next;
               end else begin
                  acc   <= mul_sum;
                  mcand <= mcand << 1;
                  opb   <= opb >> 1;
               end
               if (run_last) begin
                  state     <= FIXUP;
                  // Registered so the pulse lines up with the FIXUP cycle.
                  DivByZero <= op_div & div_zero;
               end
            end

            FIXUP: begin
               state <= IDLE;
               cnt   <= '0;
               if (op_div) begin
                  if (div_zero) begin
                     Hi <= dividend;
                     Lo <= '1;
                  end else begin
                     Hi <= rem_fix;
                     Lo <= quot_fix;
                  end
               end else begin
                  Hi <= prod_fix[2*WIDTH-1:WIDTH];
                  Lo <= prod_fix[WIDTH-1:0];
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: randomized self-checking bench for alu_muldiv_ctrl (WIDTH=32).
// Latency: expected Busy length is derived from the operation and build option.
// Backpressure: checks Stall while an op is in flight and acceptance when Busy falls.
module tb_alu_muldiv_ctrl;

   localparam int W = 32;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   ALUop;
   logic [5:0]   FuncCode;
   logic         ExValid;
   logic [W-1:0] SrcA;
   logic [W-1:0] SrcB;
   logic [3:0]   ALUCtrl;
   logic         Stall;
   logic         Busy;
   logic         UseMD;
   logic [W-1:0] MDResult;
   logic [W-1:0] Hi;
   logic [W-1:0] Lo;
   logic         DivByZero;

   int pass_cnt  = 0;
   int total_cnt = 0;

   alu_muldiv_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .ALUop(ALUop), .FuncCode(FuncCode), .ExValid(ExValid),
      .SrcA(SrcA), .SrcB(SrcB), .ALUCtrl(ALUCtrl), .Stall(Stall), .Busy(Busy),
      .UseMD(UseMD), .MDResult(MDResult), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [3:0] ref_ctrl(input logic [3:0] op, input logic [5:0] fn);
      if (op != 4'b1111) return op;
      case (fn)
         6'b000000: return 4'b0011;
         6'b000010: return 4'b0100;
         6'b000011: return 4'b1101;
         6'b100000: return 4'b0010;
         6'b100001: return 4'b1000;
         6'b100010: return 4'b0110;
         6'b100011: return 4'b1001;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b100110: return 4'b1010;
         6'b100111: return 4'b1100;
         6'b101010: return 4'b0111;
         6'b101011: return 4'b1011;
         default:   return 4'b0000;
      endcase
   endfunction

   function automatic void ref_md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
      longint          sp;
      longint unsigned up;
      int              ia, ib;
      hi = '0;
      lo = '0;
      case (fn)
         F_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            hi = sp[63:32];
            lo = sp[31:0];
         end
         F_MULTU: begin
            up = longint'({32'b0, a}) * longint'({32'b0, b});
            hi = up[63:32];
            lo = up[31:0];
         end
         default: begin
            if (b == 0) begin
               hi = a;
               lo = '1;
            end else if (fn == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               hi = '0;
               lo = 32'h8000_0000;
            end else if (fn == F_DIV) begin
               ia = a;
               ib = b;
               lo = ia / ib;
               hi = ia % ib;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [5:0] fn, input logic [W-1:0] b);
      int           n;
      logic [W-1:0] mag;
      n   = W;
      mag = (fn == F_MULT && b[W-1]) ? -b : b;
`ifdef MULDIV_EARLY_EXIT_EN
      if (fn == F_MULT || fn == F_MULTU) begin
         n = 1;
         for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
      end
`endif
      if (mag == '0 && n == 0) n = 1;
      return n + 1;
   endfunction

   // Issue one op while idle, run it to completion and check latency, pulse and results.
   task automatic run_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eh, el;
      int lat, cyc, dbz_n, dbz_at, exp_dbz_n, exp_dbz_at;
      ref_md(fn, a, b, eh, el);
      lat        = exp_lat(fn, b);
      exp_dbz_n  = ((fn == F_DIV || fn == F_DIVU) && b == 0) ? 1 : 0;
      exp_dbz_at = (exp_dbz_n == 1) ? lat - 1 : -1;
      ALUop = 4'b1111; FuncCode = fn; SrcA = a; SrcB = b; ExValid = 1'b1;
      total_cnt++;
      if (Stall !== 1'b0) $display("FAIL issue_stall fn=%b: got %b expected 0", fn, Stall); else pass_cnt++;
      tick();
      ExValid = 1'b0; SrcA = $urandom; SrcB = $urandom;
      cyc = 0; dbz_n = 0; dbz_at = -1;
      while (Busy === 1'b1 && cyc < 200) begin
         if (DivByZero === 1'b1) begin dbz_n++; dbz_at = cyc; end
         cyc++;
         tick();
      end
      total_cnt++;
      if (cyc !== lat) $display("FAIL busy_len fn=%b a=%h b=%h: got %0d expected %0d", fn, a, b, cyc, lat); else pass_cnt++;
      total_cnt++;
      if (Hi !== eh) $display("FAIL hi fn=%b a=%h b=%h: got %h expected %h", fn, a, b, Hi, eh); else pass_cnt++;
      total_cnt++;
      if (Lo !== el) $display("FAIL lo fn=%b a=%h b=%h: got %h expected %h", fn, a, b, Lo, el); else pass_cnt++;
      total_cnt++;
      if (dbz_n !== exp_dbz_n || dbz_at !== exp_dbz_at)
         $display("FAIL divbyzero fn=%b b=%h: got %0d pulses at %0d expected %0d at %0d", fn, b, dbz_n, dbz_at, exp_dbz_n, exp_dbz_at);
      else pass_cnt++;
      ExValid = 1'b1; FuncCode = F_MFHI;
      #1;
      total_cnt++;
      if (UseMD !== 1'b1 || MDResult !== eh) $display("FAIL mfhi: got usemd=%b %h expected 1 %h", UseMD, MDResult, eh); else pass_cnt++;
      ExValid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; ExValid = 1'b0; ALUop = 4'b0000; FuncCode = '0; SrcA = '0; SrcB = '0;
      tick(); tick();
      ExValid = 1'b1; ALUop = 4'b1111; FuncCode = F_MULT;
      #1;
      total_cnt++;
      if (Busy !== 1'b0 || Stall !== 1'b0) $display("FAIL reset_busy: got busy=%b stall=%b expected 0 0", Busy, Stall); else pass_cnt++;
      total_cnt++;
      if (Hi !== '0 || Lo !== '0) $display("FAIL reset_hilo: got %h %h expected 0 0", Hi, Lo); else pass_cnt++;
      total_cnt++;
      if (DivByZero !== 1'b0) $display("FAIL reset_dbz: got %b expected 0", DivByZero); else pass_cnt++;
      ExValid = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_decode();
      logic [3:0] op;
      logic [5:0] fn;
      logic [W-1:0] hi_before;
      ExValid = 1'b0; ALUop = 4'b1111;
      for (int f = 0; f < 64; f++) begin
         FuncCode = 6'(f);
         #1;
         total_cnt++;
         if (ALUCtrl !== ref_ctrl(4'b1111, 6'(f))) $display("FAIL decode funct=%b: got %b expected %b", FuncCode, ALUCtrl, ref_ctrl(4'b1111, 6'(f))); else pass_cnt++;
      end
      hi_before = Hi;
      for (int i = 0; i < 12; i++) begin
         op = 4'($urandom_range(0, 14));
         fn = (i < 4) ? F_MTHI : 6'($urandom);
         ALUop = op; FuncCode = fn; ExValid = 1'b1; SrcA = $urandom;
         #1;
         total_cnt++;
         if (ALUCtrl !== ref_ctrl(op, fn)) $display("FAIL decode_op op=%b: got %b expected %b", op, ALUCtrl, ref_ctrl(op, fn)); else pass_cnt++;
         tick();
      end
      ExValid = 1'b0;
      total_cnt++;
      if (Busy !== 1'b0 || Hi !== hi_before) $display("FAIL decode_nostate: got busy=%b hi=%h expected 0 %h", Busy, Hi, hi_before); else pass_cnt++;
   endtask

   task automatic test_move();
      logic [W-1:0] v;
      v = $urandom;
      ALUop = 4'b1111; FuncCode = F_MTHI; SrcA = 32'h0000_ABCD; ExValid = 1'b1;
      #1;
      total_cnt++;
      if (Stall !== 1'b0) $display("FAIL mthi_stall: got %b expected 0", Stall); else pass_cnt++;
      tick();
      FuncCode = F_MTLO; SrcA = v;
      total_cnt++;
      if (Hi !== 32'h0000_ABCD) $display("FAIL mthi: got %h expected 0000abcd", Hi); else pass_cnt++;
      tick();
      FuncCode = F_MFLO;
      #1;
      total_cnt++;
      if (Lo !== v || UseMD !== 1'b1 || MDResult !== v) $display("FAIL mtlo_mflo: got lo=%h usemd=%b res=%h expected %h 1 %h", Lo, UseMD, MDResult, v, v); else pass_cnt++;
      FuncCode = F_MFHI; ExValid = 1'b0;
      #1;
      total_cnt++;
      if (UseMD !== 1'b0 || MDResult !== v) $display("FAIL usemd_invalid: got %b %h expected 0 %h", UseMD, MDResult, v); else pass_cnt++;
   endtask

   task automatic test_directed();
      run_op(F_MULT,  32'hFFFF_FFFD, 32'h0000_0007);
      run_op(F_MULTU, 32'hFFFF_FFFD, 32'h0000_0007);
      run_op(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
      run_op(F_DIVU,  32'h0000_0007, 32'h0000_0002);
      run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_op(F_DIVU,  32'h0000_0005, 32'h0000_0000);
      run_op(F_DIV,   32'hFFFF_FFF9, 32'h0000_0000);
      run_op(F_MULTU, 32'h0000_0009, 32'h0000_0003);
      run_op(F_MULT,  32'h1234_5678, 32'h0000_0000);
      run_op(F_MULT,  32'h8000_0000, 32'h8000_0000);
   endtask

   task automatic test_hazard();
      logic [W-1:0] a, b, eh, el;
      int cyc, stall_bad;
      a = $urandom; b = $urandom;
      ref_md(F_MULT, a, b, eh, el);
      ALUop = 4'b1111; FuncCode = F_MULT; SrcA = a; SrcB = b; ExValid = 1'b1;
      tick();
      ExValid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      ExValid = 1'b1; FuncCode = F_MFLO;
      #1;
      cyc = 0; stall_bad = 0;
      while (Busy === 1'b1 && cyc < 200) begin
         if (Stall !== 1'b1 || UseMD !== 1'b0) stall_bad++;
         cyc++;
         tick();
      end
      total_cnt++;
      if (stall_bad !== 0 || cyc !== exp_lat(F_MULT, b) - 4)
         $display("FAIL hazard_stall: got %0d bad cycles over %0d expected 0 over %0d", stall_bad, cyc, exp_lat(F_MULT, b) - 4);
      else pass_cnt++;
      total_cnt++;
      if (Stall !== 1'b0 || UseMD !== 1'b1 || MDResult !== el)
         $display("FAIL hazard_mflo: got stall=%b usemd=%b res=%h expected 0 1 %h", Stall, UseMD, MDResult, el);
      else pass_cnt++;
      tick();
      ExValid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a1, b1, a2, b2, eh, el;
      int cyc;
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
      ref_md(F_MULTU, a1, b1, eh, el);
      ALUop = 4'b1111; FuncCode = F_MULTU; SrcA = a1; SrcB = b1; ExValid = 1'b1;
      tick();
      FuncCode = F_DIV; SrcA = a2; SrcB = b2;
      cyc = 0;
      while (Busy === 1'b1 && cyc < 200) begin cyc++; tick(); end
      total_cnt++;
      if (Hi !== eh || Lo !== el || Stall !== 1'b0) $display("FAIL b2b_first: got %h %h stall=%b expected %h %h 0", Hi, Lo, Stall, eh, el); else pass_cnt++;
      ref_md(F_DIV, a2, b2, eh, el);
      tick();
      ExValid = 1'b0;
      cyc = 0;
      while (Busy === 1'b1 && cyc < 200) begin cyc++; tick(); end
      total_cnt++;
      if (cyc !== W + 1 || Hi !== eh || Lo !== el) $display("FAIL b2b_second: got %0d %h %h expected %0d %h %h", cyc, Hi, Lo, W + 1, eh, el); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      ALUop = 4'b1111; ExValid = 1'b1;
      FuncCode = F_MTHI; SrcA = 32'h0000_1234; tick();
      FuncCode = F_MTLO; SrcA = 32'h0000_5678; tick();
      FuncCode = F_DIV;  SrcA = 32'd1000; SrcB = 32'd7; tick();
      FuncCode = F_MFHI;
      for (int i = 0; i < 9; i++) tick();
      reset = 1'b1;
      tick();
      total_cnt++;
      if (Busy !== 1'b0 || Stall !== 1'b0 || DivByZero !== 1'b0) $display("FAIL midreset_ctrl: got busy=%b stall=%b dbz=%b expected 0 0 0", Busy, Stall, DivByZero); else pass_cnt++;
      total_cnt++;
      if (Hi !== '0 || Lo !== '0) $display("FAIL midreset_hilo: got %h %h expected 0 0", Hi, Lo); else pass_cnt++;
      reset = 1'b0; ExValid = 1'b0;
      tick();
      run_op(F_MULTU, $urandom, $urandom);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 9))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'($urandom_range(1, 300));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [5:0] fns [4];
      fns[0] = F_MULT; fns[1] = F_MULTU; fns[2] = F_DIV; fns[3] = F_DIVU;
      for (int i = 0; i < 40; i++) begin
         run_op(fns[$urandom_range(0, 3)], pick_operand(), pick_operand());
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_move();
      test_directed();
      test_hazard();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
